// File: rtl/tsc_pkg.sv
// Shared constants and state encoding for the trigger surround cache.
package tsc_pkg;

  // Ring depth in samples; half of it holds history captured before the trigger.
  localparam int DEPTH = 32;
  localparam int PRE   = DEPTH / 2;

  // Default trigger threshold; a sample must exceed it to fire.
  localparam logic [7:0] TRIG_LVL_DEFAULT = 8'd200;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RUNNING   = 4'd1,
    ST_TRIGGERED = 4'd2,
    ST_DONE      = 4'd3,
    ST_SENDING   = 4'd4
  } state_t;

endpackage

// File: rtl/tsc_ring_buffer.sv
// DEPTH x 8 sample store with one write port and one combinational read port.
// Every entry clears on reset, so the store is built from flops.
module tsc_ring_buffer #(
  parameter int DEPTH = tsc_pkg::DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [DEPTH-1:0][7:0] mem;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Each entry loads when the write port addresses it; cleared on reset.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          mem[gi] <= 8'd0;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          mem[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trigger_surround_cache.sv
// Captures ADC samples into a ring, freezes it PRE-1 samples after a trigger,
// then streams the window (oldest byte first, MSB first) on sd.
module trigger_surround_cache #(
  parameter logic [7:0] TRIG_LVL = tsc_pkg::TRIG_LVL_DEFAULT,
  parameter int         DEPTH    = tsc_pkg::DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  adc_data,
  input  logic        req,
  input  logic        sbf,
  output logic        rdy,
  output logic        trd,
  output logic        cd,
  output logic [31:0] trigtm,
  output logic        sd,
  output logic [3:0]  current_state
);
  import tsc_pkg::*;

  localparam int PRE = DEPTH / 2;
  localparam int AW  = $clog2(DEPTH);
  localparam int BW  = AW + 3;

  state_t          state, state_next;
  logic [31:0]     timer;
  logic [AW-1:0]   wptr, tptr, rd_base, post_cnt, rd_addr;
  logic [BW-1:0]   bit_cnt;
  logic [7:0]      rd_data;
  logic            accept, fire, post_last, last_bit;

  // Status flags are pure decodes of the state, so they clear with it.
  assign rdy           = (state == ST_RUNNING) || (state == ST_TRIGGERED);
  assign trd           = (state == ST_TRIGGERED) || (state == ST_DONE) || (state == ST_SENDING);
  assign cd            = (state == ST_DONE) || (state == ST_SENDING);
  assign current_state = state;

  assign accept    = req && rdy;
  assign fire      = (state == ST_RUNNING) && accept && (adc_data > TRIG_LVL);
  // The sample that brings the post-count to PRE-1 completes the window.
  assign post_last = (state == ST_TRIGGERED) && accept && (post_cnt == AW'(PRE - 2));
  assign last_bit  = (bit_cnt == {BW{1'b1}});

  // Upper bits of the bit counter step through bytes; lower three pick the bit.
  assign rd_addr = rd_base + bit_cnt[BW-1:3];
  assign sd      = (state == ST_SENDING) ? rd_data[3'd7 - bit_cnt[2:0]] : 1'b0;

  tsc_ring_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_addr (wptr),
    .wr_data (adc_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode; start is only honoured in IDLE, sbf only in DONE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (start)     state_next = ST_RUNNING;
      ST_RUNNING:   if (fire)      state_next = ST_TRIGGERED;
      ST_TRIGGERED: if (post_last) state_next = ST_DONE;
      ST_DONE:      if (sbf)       state_next = ST_SENDING;
      ST_SENDING:   if (last_bit)  state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  // Timer, write pointer, trigger capture and serialiser counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer    <= 32'd0;
      wptr     <= '0;
      tptr     <= '0;
      post_cnt <= '0;
      trigtm   <= 32'd0;
      rd_base  <= '0;
      bit_cnt  <= '0;
    end else begin
      timer <= timer + 32'd1;
      if (accept) wptr <= wptr + 1'b1;
      if (fire) begin
        trigtm   <= timer;
        tptr     <= wptr;
        post_cnt <= '0;
      end else if ((state == ST_TRIGGERED) && accept) begin
        post_cnt <= post_cnt + 1'b1;
      end
      if ((state == ST_DONE) && sbf) begin
        // Oldest retained sample sits PRE slots before the trigger (mod DEPTH).
        rd_base <= tptr - AW'(PRE);
        bit_cnt <= '0;
      end else if (state == ST_SENDING) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trigger_surround_cache.sv
// Directed bench for trigger_surround_cache with a reference buffer model and
// a byte scoreboard for the serial stream.
module tb_trigger_surround_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  adc_data = 8'd0;
  logic        req = 1'b0;
  logic        sbf = 1'b0;
  logic        rdy, trd, cd, sd;
  logic [31:0] trigtm;
  logic [3:0]  current_state;

  trigger_surround_cache dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .adc_data      (adc_data),
    .req           (req),
    .sbf           (sbf),
    .rdy           (rdy),
    .trd           (trd),
    .cd            (cd),
    .trigtm        (trigtm),
    .sd            (sd),
    .current_state (current_state)
  );

  always #5 clk = ~clk;

  // Free-running reference timer.
  logic [31:0] tb_timer;
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_timer <= 32'd0;
    else        tb_timer <= tb_timer + 32'd1;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0]  mbuf [32];
  int          mwptr, m_tptr, m_post, m_st;
  logic [31:0] m_trigtm;
  logic [7:0]  exp_q [$];
  logic [7:0]  got [32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mbuf[i] = 8'd0;
    mwptr = 0; m_tptr = 0; m_post = 0; m_st = 0; m_trigtm = 32'd0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_state"}, {28'd0, current_state}, m_st);
    chk({tag, "_rdy"}, {31'd0, rdy}, (m_st == 1 || m_st == 2) ? 1 : 0);
    chk({tag, "_trd"}, {31'd0, trd}, (m_st >= 2 && m_st <= 4) ? 1 : 0);
    chk({tag, "_cd"}, {31'd0, cd}, (m_st == 3 || m_st == 4) ? 1 : 0);
  endtask

  task automatic send(input logic [7:0] d);
    logic [31:0] t_before;
    t_before = tb_timer;
    req = 1'b1;
    adc_data = d;
    tick();
    req = 1'b0;
    if (m_st == 1 || m_st == 2) begin
      mbuf[mwptr] = d;
      if (m_st == 1 && d > 8'd200) begin
        m_tptr = mwptr; m_trigtm = t_before; m_post = 0; m_st = 2;
      end else if (m_st == 2) begin
        m_post++;
        if (m_post == 15) m_st = 3;
      end
      mwptr = (mwptr + 1) % 32;
    end
    $display("sample %0d state=%0d rdy=%0d trd=%0d cd=%0d", d, current_state, rdy, trd, cd);
  endtask

  task automatic do_start(input logic with_req);
    start = 1'b1;
    req = with_req;
    adc_data = 8'd99;
    tick();
    start = 1'b0;
    req = 1'b0;
    if (m_st == 0) m_st = 1;
    $display("start req=%0d state=%0d", with_req, current_state);
  endtask

  task automatic send_buffer(input string tag);
    logic [7:0] acc;
    logic [7:0] e;
    for (int k = 0; k < 32; k++) exp_q.push_back(mbuf[(m_tptr + 16 + k) % 32]);
    sbf = 1'b1;
    tick();
    sbf = 1'b0;
    m_st = 4;
    for (int b = 0; b < 32; b++) begin
      acc = 8'd0;
      chk($sformatf("%s_send_state%0d", tag, b), {28'd0, current_state}, 4);
      for (int i = 0; i < 8; i++) begin
        acc = {acc[6:0], sd};
        tick();
      end
      e = exp_q.pop_front();
      got[b] = acc;
      chk($sformatf("%s_byte%0d", tag, b), {24'd0, acc}, {24'd0, e});
      $display("%s byte %0d = %0d", tag, b, acc);
    end
    m_st = 0;
    check_status({tag, "_after"});
    chk({tag, "_sd_idle"}, {31'd0, sd}, 0);
    chk({tag, "_trigtm_hold"}, trigtm, m_trigtm);
  endtask

  initial begin
    model_reset();
    // Reset state, observed while reset is still asserted.
    #1;
    chk("rst_state", {28'd0, current_state}, 0);
    chk("rst_outputs", {27'd0, rdy, trd, cd, sd}, 0);
    chk("rst_trigtm", trigtm, 0);
    tick(); tick();
    reset = 1'b1;

    // Scenario A: full-history capture and transfer.
    do_start(1'b0);
    send(8'd17);
    for (int i = 0; i < 9; i++) send(8'd50);
    check_status("a_run10");
    chk("a_run_state_lit", {28'd0, current_state}, 1);
    for (int i = 0; i < 10; i++) send(8'd50);
    send(8'd201);
    check_status("a_trig");
    chk("a_trigtm", trigtm, m_trigtm);
    for (int i = 1; i <= 15; i++) send(i[7:0]);
    check_status("a_done");
    chk("a_done_state_lit", {28'd0, current_state}, 3);
    send(8'd88);
    start = 1'b1; tick(); start = 1'b0;
    check_status("a_done_hold");
    send_buffer("a");
    chk("a_first50", {24'd0, got[0]}, 50);
    chk("a_last50", {24'd0, got[15]}, 50);
    chk("a_trigbyte", {24'd0, got[16]}, 201);
    chk("a_post1", {24'd0, got[17]}, 1);
    chk("a_post15", {24'd0, got[31]}, 15);

    // Scenario B: asynchronous reset while triggered.
    do_start(1'b0);
    for (int i = 0; i < 3; i++) send(8'd60);
    send(8'd250);
    check_status("b_trig");
    chk("b_trigtm", trigtm, m_trigtm);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("b_rst_state", {28'd0, current_state}, 0);
    chk("b_rst_outputs", {27'd0, rdy, trd, cd, sd}, 0);
    chk("b_rst_trigtm", trigtm, 0);
    tick(); tick();
    reset = 1'b1;

    // Scenario C: short history, simultaneous start/req, threshold equality.
    do_start(1'b1);
    check_status("c_start");
    for (int i = 0; i < 4; i++) send(8'd30);
    send(8'd200);
    check_status("c_eq_thresh");
    send(8'd201);
    check_status("c_trig");
    chk("c_trigtm", trigtm, m_trigtm);
    for (int i = 1; i <= 15; i++) send(8'(100 + i));
    check_status("c_done");
    send_buffer("c");
    chk("c_zero_first", {24'd0, got[0]}, 0);
    chk("c_zero_last", {24'd0, got[10]}, 0);
    chk("c_first_sample", {24'd0, got[11]}, 30);
    chk("c_eq_sample", {24'd0, got[15]}, 200);
    chk("c_trigbyte", {24'd0, got[16]}, 201);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
